amm_mem_responder: RTL
======================

// Module: amm_mem_responder
// PURPOSE
// - Synthesizable Avalon-MM burst slave backed by on-chip RAM: the memory-side responder that mem_checker drives.
// - Sits in the clk_mem_i domain at the mem_checker mem_* port; used in benches and on-board self-test loops.
// - Models bursts, byteenable, programmable waitrequest stalls and fixed read latency, so checker, compare and measure paths see realistic traffic.
// PARAMETERS
// - DATA_W      128  data bus width, bits (multiple of 8); DATA_B_W = DATA_W/8
// - ADDR_W      31   Avalon word-address width
// - BURST_W     11   burstcount width
// - MEM_ADDR_W  10   RAM depth = 2**MEM_ADDR_W words; only address[MEM_ADDR_W-1:0] is used
// - RD_LATENCY  4    cycles from read command accept to first readdatavalid (>=2)
// - STALL_LVL   0    waitrequest stall density 0..15; 0 = never stall
// PORTS
// - rst_i            in   1         async reset, active-high
// - clk_i            in   1         memory clock
// - address_i        in   ADDR_W    word address, sampled on first beat only
// - read_i           in   1         read command
// - write_i          in   1         write beat
// - writedata_i      in   DATA_W    write data
// - burstcount_i     in   BURST_W   beats in burst, sampled on first beat only
// - byteenable_i     in   DATA_B_W  per-beat byte lanes for writes; ignored on reads
// - waitrequest_o    out  1         1 = command/beat not accepted
// - readdatavalid_o  out  1         readdata_o valid this cycle
// - readdata_o       out  DATA_W    read data
// BEHAVIOUR
// - Reset: state IDLE, waitrequest_o=1, readdatavalid_o=0, readdata_o=0, LFSR=16'hACE1. waitrequest_o drops the first cycle after rst_i is released. RAM contents are not reset.
// - Accept rule: a beat is taken when (read_i|write_i) & !waitrequest_o. read_i&write_i together: write wins, read ignored.
// - Stall: 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every cycle. In IDLE/WR_BURST, waitrequest_o is registered (lfsr[3:0] < STALL_LVL).
// - IDLE: on accepted write, latch base=address_i and cnt=burstcount_i, write beat 0, go WR_BURST (stay IDLE if cnt==1). On accepted read, latch base/cnt and go RD_ISSUE.
// - burstcount_i==0 is treated as 1.
// - WR_BURST: each accepted beat writes RAM[base+k] with only lanes where byteenable=1 updated. address_i/burstcount_i are ignored. After beat cnt-1, go IDLE. write_i low in WR_BURST is an idle gap, with no timeout.
// - RD_ISSUE: waitrequest_o=1. One RAM read per cycle at base+k, k=0..cnt-1. Each enters a RD_LATENCY-deep valid/data pipe, so beats return back-to-back with no gaps. After the last issue, go RD_DRAIN.
// - RD_DRAIN: waitrequest_o=1 until the last beat's readdatavalid_o cycle, then IDLE. Only one read burst is outstanding at a time.
// - First read beat appears exactly RD_LATENCY cycles after the accept edge.
// - Address arithmetic: (base+k) is taken modulo 2**MEM_ADDR_W, so bursts wrap silently. The k counter is BURST_W bits wide.
// - Read-after-write to the same address in consecutive bursts returns the new data (write completes before IDLE).
// - Reset mid-burst: the burst is aborted, the pipe is flushed (no further readdatavalid_o), and partially written data remains in RAM.
// CONFIGURATION
// - MEM_RESP_ERR_INJECT_EN defined adds these ports:
//   - err_inj_en_i    in  1           fault injection enable
//   - err_inj_addr_i  in  MEM_ADDR_W  target word address
//   - A read beat from RAM address == err_inj_addr_i while err_inj_en_i=1 returns readdata_o with bit 0 inverted.
//   - RAM is untouched; err_inj_en_i is sampled at beat issue.
// - Not defined: ports absent; readdata_o always equals stored data.
// TESTING
// - STALL_LVL=0: write burst 4 @0x10, data 1..4, BE all ones; read burst 4 @0x10 -> readdatavalid 4 consecutive cycles starting RD_LATENCY after accept, data 1..4.
// - Write 0xFF..FF @0x20, then write 0 @0x20 with BE=16'h0001; read -> 0xFF..FF00.
// - Write burst 3 @0x3FF (MEM_ADDR_W=10), data A,B,C -> RAM[0x3FF]=A, RAM[0]=B, RAM[1]=C; read burst 2 @0 -> B,C.
// - STALL_LVL=8, 1000 random bursts: no beat lost or duplicated; data matches scoreboard; waitrequest_o=1 throughout every read burst.
// - Assert rst_i during RD_ISSUE of a 16-beat read -> readdatavalid_o=0 from reset; waitrequest_o=0 one cycle after release.
// - MEM_RESP_ERR_INJECT_EN, err_inj_addr_i=0x10, en=1: read @0x10 of stored 1 -> 0; en=0 -> 1.

Source files
------------

// File: rtl/amm_mem_responder.sv
// ---------------------------------------------------------------------------
// amm_mem_responder
//
// Avalon-MM burst slave backed by an on-chip RAM. This is the memory-side
// responder used behind a traffic checker. It models write bursts with
// byteenable, read bursts with a fixed read latency, and pseudo-random
// waitrequest stalls. The stalls come from a free-running 16-bit LFSR.
//
// Ports
//   rst_i            in   async reset, active-high
//   clk_i            in   memory clock
//   address_i        in   word address, sampled on the first beat only
//   read_i           in   read command
//   write_i          in   write beat
//   writedata_i      in   write data
//   burstcount_i     in   beats in burst, sampled on the first beat (0 == 1)
//   byteenable_i     in   per-beat write byte lanes
//   waitrequest_o    out  1 = command/beat not accepted
//   readdatavalid_o  out  readdata_o valid this cycle
//   readdata_o       out  read data (zero while readdatavalid_o is low)
//
// Optional build macro MEM_RESP_ERR_INJECT_EN adds:
//   err_inj_en_i     in   fault injection enable, sampled at beat issue
//   err_inj_addr_i   in   RAM word address whose read beats get bit 0 flipped
// ---------------------------------------------------------------------------
module amm_mem_responder #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 31,
  parameter int BURST_W    = 11,
  parameter int MEM_ADDR_W = 10,
  parameter int RD_LATENCY = 4,
  parameter int STALL_LVL  = 0
) (
  input  logic                  rst_i,
  input  logic                  clk_i,
  input  logic [ADDR_W-1:0]     address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [DATA_W-1:0]     writedata_i,
  input  logic [BURST_W-1:0]    burstcount_i,
  input  logic [DATA_W/8-1:0]   byteenable_i,
`ifdef MEM_RESP_ERR_INJECT_EN
  input  logic                  err_inj_en_i,
  input  logic [MEM_ADDR_W-1:0] err_inj_addr_i,
`endif
  output logic                  waitrequest_o,
  output logic                  readdatavalid_o,
  output logic [DATA_W-1:0]     readdata_o
);

  localparam int DATA_B_W = DATA_W / 8;
  localparam int DEPTH    = 1 << MEM_ADDR_W;
  localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);
  // Bit i set means an LFSR nibble of value i produces a stall.
  localparam logic [15:0] STALL_MASK = 16'((32'd1 << STALL_LVL) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_BURST = 2'd1,
    S_RD_ISSUE = 2'd2,
    S_RD_DRAIN = 2'd3
  } state_t;

  function automatic logic f_stall(input logic [15:0] lfsr);
    return STALL_MASK[lfsr[3:0]];
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_wait;
  logic [15:0]             r_lfsr;
  logic                    w_lfsr_fb;
  logic [MEM_ADDR_W-1:0]   r_base;
  logic [BURST_W-1:0]      r_cnt;
  logic [BURST_W-1:0]      r_k;
  logic [BURST_W-1:0]      w_bc_eff;
  logic [MEM_ADDR_W-1:0]   w_addr_k;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic                    w_mem_we;
  logic [MEM_ADDR_W-1:0]   w_mem_waddr;
  logic                    w_issue;
  logic                    w_issue_last;
  logic [DATA_W-1:0]       w_flip;
  logic                    w_unused;

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [RD_LATENCY-1:0]   r_vld_p;
  logic [RD_LATENCY-1:0]   r_last_p;
  logic [DATA_W-1:0]       r_data_p [RD_LATENCY];

  // Upper word-address bits select nothing: the RAM aliases across them.
  assign w_unused = ^address_i[ADDR_W-1:MEM_ADDR_W];

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  // A write beat always wins over a simultaneous read command.
  assign w_wr_acc  = write_i & ~r_wait;
  assign w_rd_acc  = read_i & ~write_i & ~r_wait;
  assign w_bc_eff  = (burstcount_i == '0) ? ONE_B : burstcount_i;
  // Burst addresses wrap modulo the RAM depth.
  assign w_addr_k  = r_base + MEM_ADDR_W'(r_k);

`ifdef MEM_RESP_ERR_INJECT_EN
  assign w_flip = {{(DATA_W-1){1'b0}}, (err_inj_en_i && (w_addr_k == err_inj_addr_i))};
`else
  assign w_flip = '0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_mem_we     = 1'b0;
    w_mem_waddr  = w_addr_k;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_acc) begin
          // Beat 0 lands immediately at the presented address.
          w_mem_we    = 1'b1;
          w_mem_waddr = address_i[MEM_ADDR_W-1:0];
          if (w_bc_eff != ONE_B) w_state_nxt = S_WR_BURST;
        end else if (w_rd_acc) begin
          w_state_nxt = S_RD_ISSUE;
        end
      end
      S_WR_BURST: begin
        if (w_wr_acc) begin
          w_mem_we = 1'b1;
          if (r_k == (r_cnt - ONE_B)) w_state_nxt = S_IDLE;
        end
      end
      S_RD_ISSUE: begin
        w_issue = 1'b1;
        if (r_k == (r_cnt - ONE_B)) begin
          w_issue_last = 1'b1;
          w_state_nxt  = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: begin
        // Leave once the final beat is on the bus this cycle.
        if (r_vld_p[RD_LATENCY-1] && r_last_p[RD_LATENCY-1]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_wait  <= 1'b1;
      r_lfsr  <= 16'hACE1;
      r_base  <= '0;
      r_cnt   <= ONE_B;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
      // Reads hold off the master until the whole burst has returned.
      if ((w_state_nxt == S_RD_ISSUE) || (w_state_nxt == S_RD_DRAIN)) begin
        r_wait <= 1'b1;
      end else begin
        r_wait <= f_stall(r_lfsr);
      end
      if ((r_state == S_IDLE) && (w_wr_acc || w_rd_acc)) begin
        r_base <= address_i[MEM_ADDR_W-1:0];
        r_cnt  <= w_bc_eff;
        r_k    <= w_wr_acc ? ONE_B : '0;
      end else if (((r_state == S_WR_BURST) && w_wr_acc) || (r_state == S_RD_ISSUE)) begin
        r_k <= r_k + ONE_B;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < DATA_B_W; b++) begin
        if (byteenable_i[b]) r_mem[w_mem_waddr][b*8 +: 8] <= writedata_i[b*8 +: 8];
      end
    end
  end

  // Stage p0: RAM read; p1..p(RD_LATENCY-1): delay line to the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld_p  <= '0;
      r_last_p <= '0;
    end else begin
      r_vld_p  <= {r_vld_p[RD_LATENCY-2:0], w_issue};
      r_last_p <= {r_last_p[RD_LATENCY-2:0], w_issue_last};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_issue) r_data_p[0] <= r_mem[w_addr_k] ^ w_flip;
    for (int i = 1; i < RD_LATENCY; i++) begin
      r_data_p[i] <= r_data_p[i-1];
    end
  end

  // Output stage: data is forced to zero whenever no beat is valid.
  assign waitrequest_o   = r_wait;
  assign readdatavalid_o = r_vld_p[RD_LATENCY-1];
  assign readdata_o      = r_vld_p[RD_LATENCY-1] ? r_data_p[RD_LATENCY-1] : '0;

endmodule
